// File: rtl/buffer_stage.sv
// buffer_stage
//   One DATA_W-wide register stage of the buffer chain.
//   rst and clear both zero the stage synchronously. When neither is
//   asserted and en is high, the stage loads d.
//
// Ports:
//   clk    clock
//   rst    synchronous reset, active-high
//   clear  synchronous flush, active-high (same effect as rst)
//   en     load enable (shift)
//   d      word to load
//   q      stored word
module buffer_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/buffer_chain.sv
// buffer_chain
//   DEPTH-stage shift buffer that feeds sliding windows of cell
//   histograms to the block-normalisation stage. Every accepted word
//   enters at stage 0, and all stages are exposed in parallel. The block
//   tracks how many stages hold valid data. Once the chain is full, it
//   raises a one-cycle window strobe every STRIDE accepted words.
//
// Ports:
//   clk          clock
//   rst          synchronous reset, active-high (overrides everything)
//   i_clear      synchronous flush of contents and counters
//   i_data       input word
//   i_valid      accept i_data this cycle (shift enable)
//   o_taps       all stages, slice k = stage k, stage 0 = newest
//   o_data       stage DEPTH-1 (oldest word)
//   o_count      number of valid stages, 0..DEPTH
//   o_full       o_count == DEPTH
//   o_win_valid  one-cycle strobe, o_taps holds a new window
module buffer_chain #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int STRIDE = 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clear,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_valid,
  output logic [DEPTH*DATA_W-1:0] o_taps,
  output logic [DATA_W-1:0]       o_data,
  output logic [CNT_W-1:0]        o_count,
  output logic                    o_full,
  output logic                    o_win_valid
);

  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FILL_C      = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] STRIDE_LAST = CNT_W'(STRIDE - 1);

  logic [DATA_W-1:0] stage_q [DEPTH];
  logic [CNT_W-1:0]  count;
  // The stride position never exceeds STRIDE-1 <= DEPTH-1, so CNT_W bits suffice.
  logic [CNT_W-1:0]  stride_pos;
  logic              win_valid;
  logic              flush;

  assign flush = rst | i_clear;

  // Stage 0 loads the input word. Every later stage loads its predecessor.
  // The word in the last stage is dropped on a shift.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [DATA_W-1:0] stage_d;

    if (k == 0) begin : g_head
      assign stage_d = i_data;
    end else begin : g_body
      assign stage_d = stage_q[k-1];
    end

    buffer_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .clear (i_clear),
      .en    (i_valid),
      .d     (stage_d),
      .q     (stage_q[k])
    );

    assign o_taps[k*DATA_W +: DATA_W] = stage_q[k];
  end

  // Occupancy saturates at DEPTH. The stride position only advances on
  // shifts that happen while the chain is already full. The shift that
  // fills the chain always produces a window, and it restarts the stride.
  always_ff @(posedge clk) begin
    if (flush) begin
      count      <= '0;
      stride_pos <= '0;
      win_valid  <= 1'b0;
    end else if (i_valid) begin
      if (count != DEPTH_C) begin
        count <= count + CNT_W'(1);
      end
      if (count == FILL_C) begin
        win_valid  <= 1'b1;
        stride_pos <= '0;
      end else if (count == DEPTH_C) begin
        if (stride_pos == STRIDE_LAST) begin
          win_valid  <= 1'b1;
          stride_pos <= '0;
        end else begin
          win_valid  <= 1'b0;
          stride_pos <= stride_pos + CNT_W'(1);
        end
      end else begin
        win_valid <= 1'b0;
      end
    end else begin
      win_valid <= 1'b0;
    end
  end

  assign o_data      = stage_q[DEPTH-1];
  assign o_count     = count;
  assign o_full      = (count == DEPTH_C);
  assign o_win_valid = win_valid;

endmodule

// File: doc/buffer_chain.md
Name: buffer_chain

Overview:
Parametrised DEPTH-stage shift buffer for the HOG pipeline. Each accepted input word shifts in at stage 0, and all stages are exposed as parallel taps. The block tracks its occupancy and emits a one-cycle window-valid strobe every STRIDE accepted words once the chain is full. It sits between the cell-histogram producer and the block-normalisation stage, which consumes sliding windows of DEPTH cells.

Parameters:
DATA_W, 32, width of one data word
DEPTH, 4, number of stages (window length); legal range >= 1
STRIDE, 1, accepted words between successive window strobes once full; legal range 1..DEPTH
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override)

Ports:
clk  input  1  the clock
rst  input  1  synchronous reset, active-high
i_clear  input  1  synchronous flush of contents and counters
i_data  input  DATA_W  input word
i_valid  input  1  accept i_data this cycle (shift enable)
o_taps  output  DEPTH*DATA_W  all stages; slice k = stage k; stage 0 = newest
o_data  output  DATA_W  stage DEPTH-1 (oldest word)
o_count  output  CNT_W  number of valid stages, 0..DEPTH
o_full  output  1  o_count == DEPTH
o_win_valid  output  1  one-cycle strobe: o_taps holds a new window

Behaviour:
- Reset (rst=1 at a clk edge): all stages 0, o_count 0, stride counter 0, o_win_valid 0. Reset overrides i_clear and i_valid.
- i_clear=1 (rst=0): identical effect to reset. i_clear has priority over i_valid; a word presented in the same cycle is discarded.
- Shift (i_valid=1, no rst/clear): stage0 <= i_data; stage k <= stage k-1 for k = 1..DEPTH-1. The word in stage DEPTH-1 is dropped.
- Hold (i_valid=0): all stages, counters and o_count unchanged; o_win_valid <= 0.
- o_count increments on each shift and saturates at DEPTH. It never wraps.
- o_full and o_data are combinational from registers.
- Stride counter s (range 0..STRIDE-1), updated only on a shift:
  - Fill shift (count before = DEPTH-1): o_win_valid <= 1, s <= 0.
  - Shift while already full (count before = DEPTH): if s == STRIDE-1 then o_win_valid <= 1 and s <= 0; else o_win_valid <= 0 and s <= s+1.
  - Shift while count before < DEPTH-1: o_win_valid <= 0, s unchanged (0).
- STRIDE=1 gives a strobe on every shift once full. DEPTH=1 gives a strobe on every accepted word.
- Latency: a word accepted at edge N is visible on o_taps slice 0 after edge N. o_win_valid is registered, updates on the same edge, and is coincident with the window it flags.
- o_win_valid is high for exactly one cycle per qualifying shift. Back-to-back qualifying shifts give consecutive high cycles.
- A partial stride is lost on clear/reset. After a clear, the next window is the first full window.
- Gaps in i_valid never reset occupancy or the stride position.

Decomposition:
- No shared package needed. CNT_W is derived locally with $clog2.
- One natural sub-module: buffer_stage, a DATA_W register with synchronous active-high rst, clear and enable. Instantiate it DEPTH times in a generate loop.
- Occupancy, stride and strobe logic stays in buffer_chain.

Test Plan:
(All with DATA_W=8, DEPTH=4, STRIDE=2.)
1. Reset: assert rst for 2 cycles with i_valid=1 and i_data=0xFF. Required after release: o_taps=0, o_data=0, o_count=0, o_full=0, o_win_valid=0.
2. Fill: push 0x11,0x22,0x33,0x44 on consecutive cycles. Required: o_count steps 1,2,3,4; after the 4th edge o_taps stage0..3 = 0x44,0x33,0x22,0x11, o_data=0x11, o_full=1, o_win_valid high for that one cycle only.
3. Stride: continue pushing 0x55, then 0x66. Required: o_win_valid=0 after 0x55; o_win_valid=1 after 0x66 with taps 0x66,0x55,0x44,0x33; o_count stays 4.
4. Gaps: repeat scenario 3 with 3 idle cycles between 0x55 and 0x66. Required: taps and o_count frozen during the gap, o_win_valid=0 during the gap, strobe still follows 0x66.
5. Clear collision: with the chain full, assert i_clear together with i_valid and i_data=0x77. Required: o_taps=0, o_count=0, o_win_valid=0, no trace of 0x77; the next 4 pushes produce a strobe on the 4th.
6. Reset mid-operation: assert rst after 2 pushes of a refill. Required: everything 0; 4 subsequent pushes strobe only on the 4th.
